// File: rtl/kws_acc_pkg.sv
// ---------------------------------------------------------------------------
// kws_acc_pkg
// Shared definitions for the KWS MAC accumulator slice:
//   - state_t           : accumulator FSM states (IDLE/ACCUM/NORM/OUT)
//   - PROD_W .. SH_W    : default widths used by the interface and modules
//   - ACC_W_OK          : elaboration-time sizing check for the defaults
//   - acc_width_ok()    : same sizing rule for arbitrary parameter sets
// Optional feature macro used elsewhere in this slice: KWS_ACC_BIAS_EN.
// ---------------------------------------------------------------------------
package kws_acc_pkg;

    localparam int PROD_W = 22;  // multiplier output width
    localparam int LEN_W  = 10;  // term-count width, max length 2^LEN_W-1
    localparam int ACC_W  = 32;  // accumulator width
    localparam int OUT_W  = 16;  // activation width
    localparam int SH_W   = 5;   // shift-amount width

    // The accumulator must hold (2^LEN_W-1) * (2^PROD_W-1) without wrapping.
    function automatic bit acc_width_ok(input int prod_w, input int len_w, input int acc_w);
        return acc_w >= prod_w + len_w;
    endfunction

    localparam bit ACC_W_OK = (ACC_W >= PROD_W + LEN_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        NORM  = 2'd2,
        OUT   = 2'd3
    } state_t;

endpackage

// File: rtl/kws_mac_acc_if.sv
// ---------------------------------------------------------------------------
// kws_mac_acc_if
// Control, product-stream and result-stream signals of kws_mac_acc.
//   start/cfg_len/cfg_shift[/cfg_bias] : job configuration, sampled in IDLE
//   in_valid/in_ready/in_data          : product stream into the accumulator
//   out_valid/out_ready/out_data/out_sat : saturated activation result
//   busy                               : accumulator not in IDLE
// cfg_bias exists only when KWS_ACC_BIAS_EN is defined.
// Modports: master = producer/consumer side, slave = kws_mac_acc.
// ---------------------------------------------------------------------------
interface kws_mac_acc_if #(
    parameter int PROD_W = kws_acc_pkg::PROD_W,
    parameter int LEN_W  = kws_acc_pkg::LEN_W,
    parameter int ACC_W  = kws_acc_pkg::ACC_W,
    parameter int OUT_W  = kws_acc_pkg::OUT_W,
    parameter int SH_W   = kws_acc_pkg::SH_W
);
    logic              start;
    logic [LEN_W-1:0]  cfg_len;
    logic [SH_W-1:0]   cfg_shift;
`ifdef KWS_ACC_BIAS_EN
    logic [ACC_W-1:0]  cfg_bias;
`endif
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_sat;
    logic              busy;

    modport master (
        output start, cfg_len, cfg_shift,
`ifdef KWS_ACC_BIAS_EN
        output cfg_bias,
`endif
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sat, busy
    );

    modport slave (
        input  start, cfg_len, cfg_shift,
`ifdef KWS_ACC_BIAS_EN
        input  cfg_bias,
`endif
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sat, busy
    );
endinterface

// File: rtl/kws_acc_norm.sv
// ---------------------------------------------------------------------------
// kws_acc_norm
// Combinational round-half-up, right-shift and unsigned saturate.
//   acc   (in)  : accumulator value
//   shift (in)  : right-shift amount; 0 means no rounding and no shift
//   data  (out) : result clipped to OUT_W bits
//   sat   (out) : result was clipped
// The rounding add is done one bit wider than the accumulator so that a
// near-full accumulator plus the rounding constant cannot wrap.
// ---------------------------------------------------------------------------
module kws_acc_norm #(
    parameter int ACC_W = kws_acc_pkg::ACC_W,
    parameter int OUT_W = kws_acc_pkg::OUT_W,
    parameter int SH_W  = kws_acc_pkg::SH_W
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [SH_W-1:0]  shift,
    output logic [OUT_W-1:0] data,
    output logic             sat
);
    import kws_acc_pkg::*;

    logic [ACC_W:0] rnd;
    logic [ACC_W:0] sum;
    logic [ACC_W:0] res;

    always_comb begin
        rnd = '0;
        if (shift != '0) begin
            rnd = (ACC_W+1)'(1) << (shift - SH_W'(1));
        end
        sum  = {1'b0, acc} + rnd;
        res  = sum >> shift;
        sat  = |res[ACC_W:OUT_W];
        data = sat ? {OUT_W{1'b1}} : res[OUT_W-1:0];
    end
endmodule

// File: rtl/kws_mac_acc.sv
// ---------------------------------------------------------------------------
// kws_mac_acc
// Accumulates cfg_len unsigned products, then rounds, shifts and saturates
// the sum to an OUT_W activation held under a valid/ready handshake.
// Ports:
//   ap_clk   : clock, rising edge
//   ap_rst_n : asynchronous active-low reset; aborts any job in flight
//   bus      : kws_mac_acc_if.slave (config, product stream, result stream)
// Optional: KWS_ACC_BIAS_EN adds cfg_bias, loaded as the initial
// accumulator value; the accumulate add then saturates at 2^ACC_W-1.
// Timing: last product accepted in cycle t -> out_valid in cycle t+2
// (one NORM cycle registers the normalised result).
// ---------------------------------------------------------------------------
module kws_mac_acc #(
    parameter int PROD_W = kws_acc_pkg::PROD_W,
    parameter int LEN_W  = kws_acc_pkg::LEN_W,
    parameter int ACC_W  = kws_acc_pkg::ACC_W,
    parameter int OUT_W  = kws_acc_pkg::OUT_W,
    parameter int SH_W   = kws_acc_pkg::SH_W
) (
    input  logic          ap_clk,
    input  logic          ap_rst_n,
    kws_mac_acc_if.slave  bus
);
    import kws_acc_pkg::*;

    if (!acc_width_ok(PROD_W, LEN_W, ACC_W)) begin : g_acc_w_check
        $error("kws_mac_acc: ACC_W must be >= PROD_W + LEN_W");
    end

    state_t            state_reg;
    state_t            state_next;
    logic [ACC_W-1:0]  acc_reg;
    logic [LEN_W-1:0]  rem_reg;
    logic [SH_W-1:0]   shift_reg;
    logic [OUT_W-1:0]  out_data_reg;
    logic              out_sat_reg;

    logic              accept;
    logic [ACC_W:0]    acc_sum;
    logic [ACC_W-1:0]  acc_add;
    logic [ACC_W-1:0]  acc_init;
    logic [OUT_W-1:0]  norm_data;
    logic              norm_sat;

    assign accept  = bus.in_valid && (state_reg == ACCUM);
    assign acc_sum = {1'b0, acc_reg} + {{(ACC_W+1-PROD_W){1'b0}}, bus.in_data};

`ifdef KWS_ACC_BIAS_EN
    // A large bias plus the products can exceed the accumulator range.
    assign acc_add  = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
    assign acc_init = bus.cfg_bias;
`else
    // Sized so that the full-length worst case never carries out.
    assign acc_add  = acc_sum[ACC_W-1:0];
    assign acc_init = '0;
`endif

    kws_acc_norm #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SH_W  (SH_W)
    ) u_norm (
        .acc   (acc_reg),
        .shift (shift_reg),
        .data  (norm_data),
        .sat   (norm_sat)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = (bus.cfg_len != '0) ? ACCUM : NORM;
                end
            end
            ACCUM: begin
                if (accept && (rem_reg == LEN_W'(1))) begin
                    state_next = NORM;
                end
            end
            NORM: begin
                state_next = OUT;
            end
            OUT: begin
                // start here is deliberately not looked at; a start in the
                // handshake cycle must be re-presented once back in IDLE.
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc_reg      <= '0;
            rem_reg      <= '0;
            shift_reg    <= '0;
            out_data_reg <= '0;
            out_sat_reg  <= 1'b0;
        end else begin
            if ((state_reg == IDLE) && bus.start) begin
                acc_reg   <= acc_init;
                rem_reg   <= bus.cfg_len;
                shift_reg <= bus.cfg_shift;
            end
            if (accept) begin
                acc_reg <= acc_add;
                rem_reg <= rem_reg - LEN_W'(1);
            end
            if (state_reg == NORM) begin
                out_data_reg <= norm_data;
                out_sat_reg  <= norm_sat;
            end
        end
    end

    assign bus.in_ready  = (state_reg == ACCUM);
    assign bus.out_valid = (state_reg == OUT);
    assign bus.busy      = (state_reg != IDLE);
    assign bus.out_data  = out_data_reg;
    assign bus.out_sat   = out_sat_reg;

endmodule

// File: tb/tb_kws_mac_acc.sv
// ---------------------------------------------------------------------------
// tb_kws_mac_acc
// Self-checking bench for kws_mac_acc: directed jobs plus randomized jobs
// (random lengths, shifts, products, input stalls, output backpressure and
// ignored start pulses) compared against an arithmetic reference model.
// Build with +define+KWS_ACC_BIAS_EN to also exercise cfg_bias.
// ---------------------------------------------------------------------------
module tb_kws_mac_acc;
    import kws_acc_pkg::*;

    localparam longint unsigned ACC_MAX = (64'd1 << ACC_W) - 64'd1;
    localparam longint unsigned OUT_MAX = (64'd1 << OUT_W) - 64'd1;
    localparam int unsigned     PROD_MAX = (32'd1 << PROD_W) - 32'd1;

    logic ap_clk = 1'b0;
    logic ap_rst_n;

    always #5 ap_clk = ~ap_clk;

    kws_mac_acc_if bus ();

    kws_mac_acc dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (bus.slave)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int job_cnt  = 0;

    task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
        chk_cnt++;
        if (got == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    // Reference: exact sum (clamped to the accumulator range), then
    // round-half-up divide by 2^shift and clip to the output range.
    task automatic model(input longint unsigned bias, input int unsigned prods[$],
                         input int shift, output longint unsigned data, output longint unsigned sat);
        longint unsigned total;
        longint unsigned r;
        total = bias;
        foreach (prods[i]) total += prods[i];
        if (total > ACC_MAX) total = ACC_MAX;
        if (shift == 0) r = total;
        else            r = (total + (64'd1 << (shift - 1))) / (64'd1 << shift);
        sat  = (r > OUT_MAX) ? 1 : 0;
        data = (r > OUT_MAX) ? OUT_MAX : r;
    endtask

    // One complete job: start, feed prods with gaps[i] idle cycles before
    // beat i, check latency, hold out_ready low for `hold` cycles while
    // pulsing start, then handshake (with a start that must be ignored).
    task automatic run_job(input int len, input int shift, input longint unsigned bias,
                           input int unsigned prods[$], input int gaps[$], input int hold,
                           input string name);
        longint unsigned exp_data;
        longint unsigned exp_sat;
        int g;
        model(bias, prods, shift, exp_data, exp_sat);
        chk({name, "_idle_busy"}, bus.busy, 0);
        bus.start     = 1'b1;
        bus.cfg_len   = LEN_W'(len);
        bus.cfg_shift = SH_W'(shift);
`ifdef KWS_ACC_BIAS_EN
        bus.cfg_bias  = bias[ACC_W-1:0];
`endif
        step();
        bus.start     = 1'b0;
        bus.cfg_len   = LEN_W'($urandom);
        bus.cfg_shift = SH_W'($urandom);
        chk({name, "_busy"}, bus.busy, 1);
        for (int i = 0; i < len; i++) begin
            g = (i < gaps.size()) ? gaps[i] : 0;
            for (int k = 0; k < g; k++) begin
                bus.in_valid = 1'b0;
                bus.in_data  = PROD_W'($urandom);
                chk({name, "_stall_ready"}, bus.in_ready, 1);
                step();
            end
            bus.in_valid = 1'b1;
            bus.in_data  = PROD_W'(prods[i]);
            chk({name, "_accept_ready"}, bus.in_ready, 1);
            step();
        end
        bus.in_valid = 1'b0;
        chk({name, "_norm_ready"}, bus.in_ready, 0);
        chk({name, "_norm_valid"}, bus.out_valid, 0);
        step();
        chk({name, "_lat_valid"}, bus.out_valid, 1);
        chk({name, "_data"}, bus.out_data, exp_data);
        chk({name, "_sat"}, bus.out_sat, exp_sat);
        for (int h = 0; h < hold; h++) begin
            bus.start   = (h % 2 == 0);
            bus.cfg_len = LEN_W'($urandom_range(1, 5));
            step();
            chk({name, "_hold_valid"}, bus.out_valid, 1);
            chk({name, "_hold_data"}, bus.out_data, exp_data);
            chk({name, "_hold_sat"}, bus.out_sat, exp_sat);
        end
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        bus.cfg_len   = LEN_W'($urandom_range(1, 5));
        step();
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        chk({name, "_hs_valid"}, bus.out_valid, 0);
        chk({name, "_hs_idle"}, bus.busy, 0);
        $display("job %0d %s len=%0d shift=%0d bias=%0d -> exp data=%0d sat=%0d",
                 job_cnt, name, len, shift, bias, exp_data, exp_sat);
        job_cnt++;
    endtask

    int unsigned pq[$];
    int          gq[$];
    int          rlen;
    int          rshift;
    longint unsigned rbias;

    initial begin
        ap_rst_n      = 1'b1;
        bus.start     = 1'b0;
        bus.cfg_len   = '0;
        bus.cfg_shift = '0;
`ifdef KWS_ACC_BIAS_EN
        bus.cfg_bias  = '0;
`endif
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #2 ap_rst_n = 1'b0;
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_sat", bus.out_sat, 0);
        step();
        step();
        ap_rst_n = 1'b1;
        step();

        // Back-to-back sum with backpressure and ignored start pulses.
        pq = {100, 200, 300, 400}; gq = {};
        run_job(4, 0, 0, pq, gq, 5, "sum1000");
        // Rounded shift.
        pq = {500, 500, 2};
        run_job(3, 2, 0, pq, gq, 0, "round251");
        // Saturation of one maximum product.
        pq = {PROD_MAX};
        run_job(1, 0, 0, pq, gq, 1, "sat_max");
        // Full-length job of maximum products.
        pq = {};
        for (int i = 0; i < 1023; i++) pq.push_back(PROD_MAX);
        run_job(1023, 16, 0, pq, gq, 0, "len1023");
        // in_valid pattern 1,0,0,1.
        pq = {7000, 12345}; gq = {0, 2};
        run_job(2, 0, 0, pq, gq, 2, "stall");
        // Zero-length job.
        pq = {}; gq = {};
        run_job(0, 0, 0, pq, gq, 0, "len0");

        // Reset in the middle of a job: no result must appear.
        pq = {11, 22}; gq = {};
        run_job(2, 0, 0, pq, gq, 0, "pre_rst");
        bus.start   = 1'b1;
        bus.cfg_len = LEN_W'(4);
        bus.cfg_shift = '0;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = PROD_W'(50 + i);
            step();
        end
        bus.in_valid = 1'b0;
        #2 ap_rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_in_ready", bus.in_ready, 0);
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_out_data", bus.out_data, 0);
        chk("mid_rst_out_sat", bus.out_sat, 0);
        step();
        ap_rst_n = 1'b1;
        step();
        chk("post_rst_out_valid", bus.out_valid, 0);
        pq = {7, 8};
        run_job(2, 0, 0, pq, gq, 0, "fresh15");

`ifdef KWS_ACC_BIAS_EN
        pq = {24};
        run_job(1, 3, 1000, pq, gq, 0, "bias128");
        pq = {};
        run_job(0, 4, 123456, pq, gq, 0, "bias_len0");
        pq = {PROD_MAX, PROD_MAX};
        run_job(2, 16, ACC_MAX - 64'd5, pq, gq, 0, "bias_sat");
`endif

        // Randomized jobs.
        for (int j = 0; j < 40; j++) begin
            rlen   = $urandom_range(0, 24);
            rshift = $urandom_range(0, 31);
            rbias  = 0;
`ifdef KWS_ACC_BIAS_EN
            rbias = ($urandom_range(0, 3) == 0) ? (ACC_MAX - longint'($urandom_range(0, 1 << 24)))
                                                : longint'($urandom);
`endif
            pq = {}; gq = {};
            for (int i = 0; i < rlen; i++) begin
                pq.push_back($urandom_range(0, PROD_MAX));
                gq.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
            end
            run_job(rlen, rshift, rbias, pq, gq, $urandom_range(0, 4), "rand");
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
